// File: rtl/key_event_queue.sv
// Button press tracker feeding a small event FIFO: one press is followed from tick to release.
// Define KEY_EVENT_LONG_EN to add the hold counter and the per-event long-press flag.
module key_event_queue #(
    parameter int LONG_CYCLES = 25000000,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_level,
    input  logic [3:0] btn_tick,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [1:0] ev_code,
    output logic       ev_long,
    output logic [4:0] ev_count,
    output logic       busy,
    output logic       overflow
);
    localparam int PW = $clog2(DEPTH);

    if (LONG_CYCLES < 2 || DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("key_event_queue: illegal LONG_CYCLES/DEPTH");
    end

    typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_e;

    state_e state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       push_req;
    logic [1:0] push_code;
    logic       push_long;

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

`ifdef KEY_EVENT_LONG_EN
    localparam int CW = $clog2(LONG_CYCLES + 1);
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES);
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
`ifdef KEY_EVENT_LONG_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
`ifdef KEY_EVENT_LONG_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
`ifdef KEY_EVENT_LONG_EN
        hold_cnt_d = hold_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|btn_tick) begin
                    state_d = HELD;
                    idx_d   = lowest_set(btn_tick);
`ifdef KEY_EVENT_LONG_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            HELD: begin
                // Ticks are ignored here; only the tracked button's level matters.
                if (btn_level[idx_q]) begin
`ifdef KEY_EVENT_LONG_EN
                    if (hold_cnt_q != LONG_MAX) hold_cnt_d = hold_cnt_q + CW'(1);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == HELD);
        push_req  = (state_q == HELD) && !btn_level[idx_q];
        push_code = idx_q;
`ifdef KEY_EVENT_LONG_EN
        push_long = (hold_cnt_q == LONG_MAX);
`else
        push_long = 1'b0;
`endif
    end

    logic [1:0]    code_mem_q [DEPTH];
    logic [1:0]    code_mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          do_push, do_pop, full;

`ifdef KEY_EVENT_LONG_EN
    logic [DEPTH-1:0] long_mem_q, long_mem_d;
`endif

    always_comb begin
        full       = (count_q == 5'(DEPTH));
        do_pop     = (count_q != 5'd0) && ev_ready;
        // A pop in the same cycle frees the slot the push needs.
        do_push    = push_req && (!full || do_pop);
        overflow_d = overflow_q | (push_req && full && !do_pop);
        wr_ptr_d   = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + 5'(do_push) - 5'(do_pop);
        code_mem_d = code_mem_q;
        if (do_push) code_mem_d[wr_ptr_q] = push_code;
`ifdef KEY_EVENT_LONG_EN
        long_mem_d = long_mem_q;
        if (do_push) long_mem_d[wr_ptr_q] = push_long;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 5'd0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) code_mem_q[i] <= 2'd0;
`ifdef KEY_EVENT_LONG_EN
            long_mem_q <= '0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            code_mem_q <= code_mem_d;
`ifdef KEY_EVENT_LONG_EN
            long_mem_q <= long_mem_d;
`endif
        end
    end

    assign ev_valid = (count_q != 5'd0);
    assign ev_code  = code_mem_q[rd_ptr_q];
    assign ev_count = count_q;
    assign overflow = overflow_q;
`ifdef KEY_EVENT_LONG_EN
    assign ev_long  = long_mem_q[rd_ptr_q];
`else
    assign ev_long  = 1'b0;
`endif

endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter: LONG_CYCLES, 25000000, hold duration in clk cycles that qualifies a long press (0.5 s at 50 MHz); legal range >= 2.
REQ-002 Parameter: DEPTH, 4, event FIFO entries; power of two, range 2..16.
REQ-003 Port: clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: btn_level  input  4  debounced button levels; bit i is button i.
REQ-006 Port: btn_tick  input  4  debounced one-cycle press pulses; bit i is button i.
REQ-007 Port: ev_ready  input  1  consumer accepts the head event.
REQ-008 Port: ev_valid  output  1  FIFO not empty; head event present.
REQ-009 Port: ev_code  output  2  button index of head event.
REQ-010 Port: ev_long  output  1  head event was a long press.
REQ-011 Port: ev_count  output  5  number of stored events, 0..DEPTH.
REQ-012 Port: busy  output  1  a press is being tracked (FSM in HELD).
REQ-013 Port: overflow  output  1  sticky: one or more events dropped because the FIFO was full.

Function
REQ-014 FSM states: IDLE, HELD; register idx[1:0] holds the tracked button.
REQ-015 IDLE: if any btn_tick bit is 1 at an edge, go to HELD; idx = lowest set bit index; hold_cnt = 0.
REQ-016 HELD: ticks on any button are ignored; no second press is tracked concurrently.
REQ-017 HELD: btn_level[idx]=1 -> hold_cnt += 1, saturating at LONG_CYCLES.
REQ-018 HELD: btn_level[idx]=0 at edge k -> push {idx, hold_cnt==LONG_CYCLES} at edge k, go to IDLE; ev_valid visible after edge k.
REQ-019 A tick arriving in the same cycle as the release is ignored; tracking of a new press begins only from IDLE.
REQ-020 Pop at an edge where ev_valid=1 and ev_ready=1; head advances; ev_count decrements.
REQ-021 ev_code and ev_long come straight from FIFO storage at the read pointer; they are stable while ev_valid=1 and ev_ready=0.
REQ-022 Push when full without a simultaneous pop: event dropped, FIFO unchanged, overflow set.
REQ-023 Push when full with a simultaneous pop: both take effect; ev_count stays DEPTH; overflow unchanged.
REQ-024 Push and pop on an empty FIFO: push only; ev_count = 1.
REQ-025 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; ev_count is kept separately.
REQ-026 ev_code and ev_long are don't-care while ev_valid=0.

Reset
REQ-027 rst=1 at an edge forces: FSM IDLE, idx=0, hold_cnt=0, pointers=0, ev_count=0, ev_valid=0, busy=0, overflow=0; ev_code and ev_long read 0.
REQ-028 rst takes priority over every push, pop, and FSM transition in the same cycle.
REQ-029 Reset during HELD discards the tracked press; a button still held after reset produces no event until its next tick.
REQ-030 overflow clears only on rst.

Configuration
REQ-031 Macro KEY_EVENT_LONG_EN defined: hold_cnt and long-press detection present, per REQ-017/018.
REQ-032 Macro KEY_EVENT_LONG_EN undefined: no hold_cnt or long FIFO bit; ev_long is constant 0; LONG_CYCLES is unused; all other behaviour is identical.

Verification (LONG_CYCLES=8, DEPTH=4, KEY_EVENT_LONG_EN defined unless stated)
REQ-033 Tick on button 2, level held for 3 cycles, then released -> one event, ev_code=2, ev_long=0, ev_count=1, busy low after the release edge.
REQ-034 Tick on button 1, level held for 20 cycles -> ev_code=1, ev_long=1; hold_cnt saturates at 8 with no wrap.
REQ-035 btn_tick=4'b1010 in the same cycle -> only button 1 is tracked; a button 3 tick during HELD produces no event.
REQ-036 Six presses with ev_ready=0 -> ev_count=4, overflow=1; drain -> first four codes in order, then ev_valid=0.
REQ-037 FIFO full, ev_ready=1 in the same cycle a release completes -> ev_count stays 4, overflow stays 0, order preserved.
REQ-038 rst pulsed mid-HELD with 2 events queued -> all outputs 0 next cycle; release of the still-held button produces no event; KEY_EVENT_LONG_EN undefined rerun of REQ-034 -> ev_long=0.
